mem_port_arbiter: RTL and testbench

- Shares the single byte-enabled scratch memory wrapper between two requesters: instruction fetch (port F, read-only) and load/store (port D, read/write).
- Sequences each transaction on the wrapper's enable/busy interface and returns read data to the requester.
- Sits between the core's fetch/LSU stages and the memory wrapper.
- Arbitration is fixed priority to D, with a starvation guard for F.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one enable/busy scratch-memory wrapper between a read-only fetch port (F)
// and a load/store port (D); D has priority, F is forced after a run of D grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [13:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [13:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_enable,
  output logic [13:0] m_addr,
  output logic [31:0] m_data,
  output logic [3:0]  m_be,
  output logic        m_write,
  input  logic        m_busy,
  input  logic [31:0] m_rdata,
  output logic        grant
);

  localparam int unsigned CW = (STARVE_LIMIT < 32'd1) ? 32'd1 : $clog2(STARVE_LIMIT + 32'd1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] starve_r;
  logic          we_r;
  logic          pick_d_s;

  // Winner selection: D unless F has waited through LIMIT consecutive D grants.
  always_comb begin
    pick_d_s = 1'b0;
    if (f_req && d_req) begin
      pick_d_s = (starve_r != LIMIT);
    end else begin
      pick_d_s = d_req;
    end
  end

  // Transaction sequencer; every output is a register written here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      starve_r <= {CW{1'b0}};
      we_r     <= 1'b0;
      f_ack    <= 1'b0;
      d_ack    <= 1'b0;
      f_rdata  <= 32'h0000_0000;
      d_rdata  <= 32'h0000_0000;
      m_enable <= 1'b0;
      m_addr   <= 14'h0000;
      m_data   <= 32'h0000_0000;
      m_be     <= 4'b0000;
      m_write  <= 1'b0;
      grant    <= 1'b0;
    end else begin
      f_ack    <= 1'b0;
      d_ack    <= 1'b0;
      m_enable <= 1'b0;
      m_write  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // The wrapper stays busy after its own reset; never start while it is.
          if (!m_busy && (f_req || d_req)) begin
            state_r  <= S_ISSUE;
            m_enable <= 1'b1;
            if (pick_d_s) begin
              grant   <= 1'b1;
              m_addr  <= d_addr;
              m_data  <= d_wdata;
              m_be    <= d_be;
              m_write <= d_we;
              we_r    <= d_we;
              if (!f_req) begin
                starve_r <= {CW{1'b0}};
              end else if (starve_r != LIMIT) begin
                starve_r <= starve_r + CW'(1'b1);
              end else begin
                starve_r <= starve_r;
              end
            end else begin
              grant    <= 1'b0;
              m_addr   <= f_addr;
              m_be     <= 4'b0000;
              we_r     <= 1'b0;
              starve_r <= {CW{1'b0}};
            end
          end
        end
        S_ISSUE: begin
          state_r <= S_ARM;
        end
        S_ARM: begin
          if (m_busy) begin
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          if (!m_busy) begin
            state_r <= S_DONE;
            if (grant) begin
              d_ack <= 1'b1;
              if (!we_r) begin
                d_rdata <= m_rdata;
              end
            end else begin
              f_ack   <= 1'b1;
              f_rdata <= m_rdata;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: wrapper models with a busy handshake, a reference
// memory plus a starvation-rule model for expected grants and read data.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        f_req, d_req, d_we;
  logic [13:0] f_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        f_ack, d_ack, m_enable, m_write, grant;
  logic [31:0] f_rdata, d_rdata, m_data;
  logic [13:0] m_addr;
  logic [3:0]  m_be;
  logic        m_busy = 1'b1;
  logic [31:0] m_rdata = 32'h0;

  logic        z_f_req, z_d_req;
  logic [13:0] z_f_addr, z_d_addr;
  logic        z_f_ack, z_d_ack, z_m_enable, z_m_write, z_grant;
  logic [31:0] z_f_rdata, z_d_rdata, z_m_data;
  logic [13:0] z_m_addr;
  logic [3:0]  z_m_be;
  logic        z_m_busy = 1'b1;
  logic [31:0] z_m_rdata = 32'h0;

  int errors = 0;
  int checks = 0;
  int busy_len = 2;
  int cnt = 0;
  int z_cnt = 0;
  int en_count = 0;
  bit hold_busy = 1'b1;
  logic [31:0] mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] exp_f, exp_d;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_enable(m_enable), .m_addr(m_addr), .m_data(m_data), .m_be(m_be),
    .m_write(m_write), .m_busy(m_busy), .m_rdata(m_rdata), .grant(grant)
  );

  mem_port_arbiter #(.STARVE_LIMIT(0)) dut_z (
    .clk(clk), .reset(reset),
    .f_req(z_f_req), .f_addr(z_f_addr), .f_ack(z_f_ack), .f_rdata(z_f_rdata),
    .d_req(z_d_req), .d_we(1'b0), .d_addr(z_d_addr), .d_wdata(32'h0), .d_be(4'b0000),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .m_enable(z_m_enable), .m_addr(z_m_addr), .m_data(z_m_data), .m_be(z_m_be),
    .m_write(z_m_write), .m_busy(z_m_busy), .m_rdata(z_m_rdata), .grant(z_grant)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // Wrapper model: busy rises the edge after an enable and stays high busy_len cycles.
  always @(posedge clk) begin
    if (m_enable) en_count <= en_count + 1;
    if (hold_busy) begin
      m_busy <= 1'b1;
      cnt    <= 0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) m_busy <= 1'b0;
    end else if (m_enable) begin
      m_busy <= 1'b1;
      cnt    <= busy_len;
      if (m_write) mem[m_addr[13:2]] <= merge(mem[m_addr[13:2]], m_data, m_be);
      else m_rdata <= mem[m_addr[13:2]];
    end else begin
      m_busy <= 1'b0;
    end
  end

  // Second wrapper model: read data echoes the address.
  always @(posedge clk) begin
    if (hold_busy) begin
      z_m_busy <= 1'b1;
      z_cnt    <= 0;
    end else if (z_cnt != 0) begin
      z_cnt <= z_cnt - 1;
      if (z_cnt == 1) z_m_busy <= 1'b0;
    end else if (z_m_enable) begin
      z_m_busy  <= 1'b1;
      z_cnt     <= 2;
      z_m_rdata <= {18'h0, z_m_addr};
    end else begin
      z_m_busy <= 1'b0;
    end
  end

  task automatic wait_enable(input bit z, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (z ? z_m_enable : m_enable) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input bit z, input bit want_d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (z ? (want_d ? z_d_ack : z_f_ack) : (want_d ? d_ack : f_ack)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b0; hold_busy = 1'b1;
    f_req = 1'b1; f_addr = 14'h010;
    d_req = 1'b0; d_we = 1'b0; d_addr = 14'h0; d_wdata = 32'h0; d_be = 4'b0000;
    z_f_req = 1'b0; z_d_req = 1'b0; z_f_addr = 14'h100; z_d_addr = 14'h200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({f_ack, d_ack, m_enable, m_write, grant, m_be, m_addr} !== 23'h0) begin
        errors++; $display("FAIL reset_ctrl got=%h exp=0", {f_ack, d_ack, m_enable, m_write, grant, m_be, m_addr});
      end
      checks++;
      if ({f_rdata, d_rdata, m_data} !== 96'h0) begin
        errors++; $display("FAIL reset_data got=%h exp=0", {f_rdata, d_rdata, m_data});
      end
    end
    exp_f = 32'h0; exp_d = 32'h0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m_enable !== 1'b0) begin
        errors++; $display("FAIL busy_hold got=%b exp=0", m_enable);
      end
    end
    hold_busy = 1'b0;
    wait_enable(1'b0, ok);
    checks++;
    if (!ok || m_addr !== 14'h010 || grant !== 1'b0) begin
      errors++; $display("FAIL post_reset_fetch got=%b/%h/%b exp=1/010/0", ok, m_addr, grant);
    end
    wait_ack(1'b0, 1'b0, ok);
    f_req = 1'b0;
    exp_f = ref_mem[4];
    checks++;
    if (!ok || f_rdata !== exp_f) begin
      errors++; $display("FAIL post_reset_rdata got=%b/%h exp=1/%h", ok, f_rdata, exp_f);
    end
  endtask

  task automatic test_single_fetch();
    bit ok;
    int en0;
    mem[1] = 32'hDEADBEEF; ref_mem[1] = 32'hDEADBEEF;
    busy_len = 2;
    @(negedge clk);
    en0 = en_count;
    f_req = 1'b1; f_addr = 14'h004;
    wait_enable(1'b0, ok);
    checks++;
    if (!ok || m_addr !== 14'h004 || m_write !== 1'b0 || m_be !== 4'b0000 || grant !== 1'b0) begin
      errors++; $display("FAIL fetch_issue got=%b/%h/%b/%b/%b exp=1/004/0/0/0", ok, m_addr, m_write, m_be, grant);
    end
    wait_ack(1'b0, 1'b0, ok);
    f_req = 1'b0;
    exp_f = 32'hDEADBEEF;
    checks++;
    if (!ok || f_rdata !== exp_f || d_rdata !== exp_d || d_ack !== 1'b0) begin
      errors++; $display("FAIL fetch_data got=%b/%h/%h/%b exp=1/%h/%h/0", ok, f_rdata, d_rdata, d_ack, exp_f, exp_d);
    end
    @(negedge clk);
    checks++;
    if (f_ack !== 1'b0 || en_count - en0 !== 1) begin
      errors++; $display("FAIL fetch_pulse got=%b/%0d exp=0/1", f_ack, en_count - en0);
    end
  endtask

  task automatic test_store();
    bit ok;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h020; d_wdata = 32'h11223344; d_be = 4'b0011;
    wait_enable(1'b0, ok);
    checks++;
    if (!ok || m_write !== 1'b1 || m_be !== 4'b0011 || m_addr !== 14'h020 ||
        m_data !== 32'h11223344 || grant !== 1'b1) begin
      errors++; $display("FAIL store_issue got=%b/%b/%b/%h/%h/%b exp=1/1/0011/020/11223344/1",
                         ok, m_write, m_be, m_addr, m_data, grant);
    end
    @(negedge clk);
    checks++;
    if (m_write !== 1'b0 || m_enable !== 1'b0 || m_be !== 4'b0011 || m_addr !== 14'h020) begin
      errors++; $display("FAIL store_arm got=%b/%b/%b/%h exp=0/0/0011/020", m_write, m_enable, m_be, m_addr);
    end
    ref_mem[8] = merge(ref_mem[8], 32'h11223344, 4'b0011);
    wait_ack(1'b0, 1'b1, ok);
    d_req = 1'b0; d_we = 1'b0;
    checks++;
    if (!ok || d_rdata !== exp_d || f_ack !== 1'b0) begin
      errors++; $display("FAIL store_ack got=%b/%h/%b exp=1/%h/0", ok, d_rdata, f_ack, exp_d);
    end
    @(negedge clk);
    d_req = 1'b1; d_addr = 14'h020;
    wait_ack(1'b0, 1'b1, ok);
    d_req = 1'b0;
    exp_d = ref_mem[8];
    checks++;
    if (!ok || d_rdata !== exp_d || f_rdata !== exp_f) begin
      errors++; $display("FAIL load_back got=%b/%h/%h exp=1/%h/%h", ok, d_rdata, f_rdata, exp_d, exp_f);
    end
  endtask

  task automatic test_contention();
    bit ok, exp_is_d;
    int s;
    s = 0;
    @(negedge clk);
    f_req = 1'b1; f_addr = 14'h040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h044;
    for (int k = 0; k < 10; k++) begin
      exp_is_d = (s != 4);
      s = exp_is_d ? ((s < 4) ? s + 1 : s) : 0;
      wait_enable(1'b0, ok);
      checks++;
      if (!ok || grant !== exp_is_d || m_addr !== (exp_is_d ? 14'h044 : 14'h040)) begin
        errors++; $display("FAIL contention_grant[%0d] got=%b/%b/%h exp=1/%b", k, ok, grant, m_addr, exp_is_d);
      end
      wait_ack(1'b0, exp_is_d, ok);
      if (k == 9) begin
        f_req = 1'b0; d_req = 1'b0;
      end
      if (exp_is_d) exp_d = ref_mem[17];
      else exp_f = ref_mem[16];
      checks++;
      if (!ok || (exp_is_d ? f_ack : d_ack) !== 1'b0 || f_rdata !== exp_f || d_rdata !== exp_d) begin
        errors++; $display("FAIL contention_ack[%0d] got=%b/%b/%b/%h/%h exp=1 data %h/%h",
                           k, ok, f_ack, d_ack, f_rdata, d_rdata, exp_f, exp_d);
      end
    end
  endtask

  task automatic test_starve_zero();
    bit ok;
    @(negedge clk);
    z_f_req = 1'b1; z_d_req = 1'b1;
    wait_enable(1'b1, ok);
    checks++;
    if (!ok || z_grant !== 1'b0) begin
      errors++; $display("FAIL zero_limit_first got=%b/%b exp=1/0", ok, z_grant);
    end
    wait_ack(1'b1, 1'b0, ok);
    z_f_req = 1'b0;
    checks++;
    if (!ok || z_f_rdata !== 32'h0000_0100) begin
      errors++; $display("FAIL zero_limit_fdata got=%b/%h exp=1/00000100", ok, z_f_rdata);
    end
    wait_enable(1'b1, ok);
    checks++;
    if (!ok || z_grant !== 1'b1) begin
      errors++; $display("FAIL zero_limit_second got=%b/%b exp=1/1", ok, z_grant);
    end
    wait_ack(1'b1, 1'b1, ok);
    z_d_req = 1'b0;
    checks++;
    if (!ok || z_d_rdata !== 32'h0000_0200) begin
      errors++; $display("FAIL zero_limit_ddata got=%b/%h exp=1/00000200", ok, z_d_rdata);
    end
  endtask

  task automatic test_abort();
    bit ok;
    busy_len = 6;
    @(negedge clk);
    f_req = 1'b1; f_addr = 14'h050;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h054;
    wait_enable(1'b0, ok);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({f_ack, d_ack, m_enable, grant} !== 4'b0000 || {f_rdata, d_rdata} !== 64'h0) begin
        errors++; $display("FAIL abort_reset got=%b%b%b%b/%h/%h exp=0000/0/0",
                           f_ack, d_ack, m_enable, grant, f_rdata, d_rdata);
      end
    end
    exp_f = 32'h0; exp_d = 32'h0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    busy_len = 2;
    hold_busy = 1'b0;
    wait_enable(1'b0, ok);
    checks++;
    if (!ok || grant !== 1'b1 || m_addr !== 14'h054) begin
      errors++; $display("FAIL abort_regrant got=%b/%b/%h exp=1/1/054", ok, grant, m_addr);
    end
    wait_ack(1'b0, 1'b1, ok);
    f_req = 1'b0; d_req = 1'b0;
    exp_d = ref_mem[21];
    checks++;
    if (!ok || d_rdata !== exp_d || f_rdata !== exp_f) begin
      errors++; $display("FAIL abort_data got=%b/%h/%h exp=1/%h/%h", ok, d_rdata, f_rdata, exp_d, exp_f);
    end
    wait_ack(1'b0, 1'b0, ok);
    checks++;
    if (ok) begin
      errors++; $display("FAIL abort_stale_fack got=1 exp=0");
    end
  endtask

  task automatic test_random();
    bit ok;
    int kind, w;
    logic [31:0] wd;
    logic [3:0] be;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      w = $urandom_range(0, 63);
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      busy_len = $urandom_range(1, 4);
      @(negedge clk);
      if (kind == 0) begin
        f_req = 1'b1; f_addr = 14'(w * 4);
      end else begin
        d_req = 1'b1; d_we = (kind == 2); d_addr = 14'(w * 4); d_wdata = wd; d_be = be;
      end
      wait_enable(1'b0, ok);
      checks++;
      if (!ok || m_addr !== 14'(w * 4) || grant !== (kind != 0) || m_write !== (kind == 2) ||
          m_be !== ((kind == 2 || kind == 1) ? be : 4'b0000)) begin
        errors++; $display("FAIL rand_issue[%0d] got=%b/%h/%b/%b/%b kind=%0d", n, ok, m_addr, grant, m_write, m_be, kind);
      end
      if (kind == 2) ref_mem[w] = merge(ref_mem[w], wd, be);
      wait_ack(1'b0, kind != 0, ok);
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if (kind == 0) exp_f = ref_mem[w];
      if (kind == 1) exp_d = ref_mem[w];
      checks++;
      if (!ok || f_rdata !== exp_f || d_rdata !== exp_d) begin
        errors++; $display("FAIL rand_data[%0d] got=%b/%h/%h exp=1/%h/%h", n, ok, f_rdata, d_rdata, exp_f, exp_d);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_starve_zero();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
